// File: rtl/lbp_host.sv
// Host-side responder for the LBP engine: frame loader, pixel server, result store.
// Define LBP_HOST_WRCHK_EN to compile in the border checker and write counter.
module lbp_host #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [7:0]        gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              border_err
);

  localparam int CW    = $clog2(IMG_W);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] load_ptr;
  logic [7:0]        gray_mem [DEPTH];
  logic [7:0]        lbp_mem  [DEPTH];
  logic              load_we;
  logic              lbp_we;

  assign load_we = (state == LOAD) && load_valid;
  assign lbp_we  = (state == SERVE) && lbp_valid;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (load_we)
      gray_mem[load_ptr] <= load_data;
    if (lbp_we)
      lbp_mem[lbp_addr] <= lbp_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      load_ptr   <= '0;
      gray_ready <= 1'b0;
      gray_data  <= '0;
      done       <= 1'b0;
      rd_data    <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (load_valid) begin
            load_ptr <= load_ptr + 1'b1;
            if (&load_ptr) begin
              state      <= SERVE;
              gray_ready <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (gray_req)
            gray_data <= gray_mem[gray_addr];
          if (finish) begin
            state      <= DONE;
            gray_ready <= 1'b0;
            done       <= 1'b1;
          end
        end
        DONE: begin
          rd_data <= lbp_mem[rd_addr];
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef LBP_HOST_WRCHK_EN
  logic [ADDR_W:0]      cnt_q;
  logic                 berr_q;
  logic [CW-1:0]        col;
  logic [ADDR_W-CW-1:0] row;
  logic                 is_border;

  assign col = lbp_addr[CW-1:0];
  assign row = lbp_addr[ADDR_W-1:CW];
  assign is_border = (row == '0) || (&row)
                  || (col == '0) || (&col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else if (lbp_we) begin
      if (cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
      if (is_border)
        berr_q <= 1'b1;
    end
  end

  assign wr_cnt     = cnt_q;
  assign border_err = berr_q;
`else
  assign wr_cnt     = '0;
  assign border_err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_host.sv
// Directed scoreboard bench for lbp_host at IMG_W=4, ADDR_W=4.
module tb_lbp_host;

  localparam int IMG_W  = 4;
  localparam int ADDR_W = 4;

`ifdef LBP_HOST_WRCHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [7:0]        gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [ADDR_W:0]   wr_cnt;
  logic              border_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  lbp_host #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data),
    .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr),
    .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
    .lbp_data(lbp_data),
    .finish(finish), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_cnt(wr_cnt), .border_err(border_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag, input logic [7:0] obs);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'(sb.size()), 16'd1);
    end else begin
      exp_b = sb.pop_front();
      check(tag, 16'(obs), 16'(exp_b));
    end
  endtask

  task automatic cnt_chk(input string tag, input int n, input bit b);
    check({tag, "_wr_cnt"}, 16'(wr_cnt), CHK ? 16'(n) : 16'd0);
    check({tag, "_border"}, 16'(border_err), CHK ? 16'(b) : 16'd0);
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_data = 0;
    gray_req = 0; gray_addr = 0;
    lbp_valid = 0; lbp_addr = 0; lbp_data = 0;
    finish = 0; rd_addr = 0;
  endtask

  task automatic load_frame(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3 == 1)) begin
        load_valid = 0;
        tick();
      end
      load_valid = 1;
      load_data  = base + 8'(i);
      tick();
      load_valid = 0;
      if (i >= 14)
        check($sformatf("gray_ready_beat%0d", i), 16'(gray_ready),
              16'(i == 15));
    end
  endtask

  task automatic read_pix(input logic [3:0] a, input logic [7:0] e);
    gray_req  = 1;
    gray_addr = a;
    sb.push_back(e);
    tick();
    gray_req = 0;
    chk_sb($sformatf("gray_a%0d", a), gray_data);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    lbp_valid = 1;
    lbp_addr  = a;
    lbp_data  = d;
    tick();
    lbp_valid = 0;
  endtask

  task automatic rd_back(input logic [3:0] a, input logic [7:0] e);
    rd_addr = a;
    sb.push_back(e);
    tick();
    chk_sb($sformatf("rd_a%0d", a), rd_data);
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    tick();
    tick();
    check("rst_gray_ready", 16'(gray_ready), 16'd0);
    check("rst_gray_data", 16'(gray_data), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_rd_data", 16'(rd_data), 16'd0);
    check("rst_wr_cnt", 16'(wr_cnt), 16'd0);
    check("rst_border", 16'(border_err), 16'd0);
    reset = 1;
    tick();

    load_frame(8'h10, 1'b1);

    // beats after the frame must not touch memory
    load_valid = 1; load_data = 8'hEE;
    tick();
    tick();
    load_valid = 0;

    // back-to-back reads
    gray_req = 1;
    gray_addr = 4'd5; sb.push_back(8'h15);
    tick();
    chk_sb("b2b_0", gray_data);
    gray_addr = 4'd6; sb.push_back(8'h16);
    tick();
    chk_sb("b2b_1", gray_data);
    gray_addr = 4'd9; sb.push_back(8'h19);
    tick();
    chk_sb("b2b_2", gray_data);
    gray_req = 0;
    gray_addr = 4'd0;
    tick();
    check("gray_hold0", 16'(gray_data), 16'h19);
    tick();
    check("gray_hold1", 16'(gray_data), 16'h19);
    read_pix(4'd0, 8'h10);
    read_pix(4'd15, 8'h1F);
    check("rd_data_serve", 16'(rd_data), 16'd0);

    wr(4'd5, 8'hA5);
    cnt_chk("w1", 1, 0);
    wr(4'd5, 8'h3C);
    cnt_chk("w2", 2, 0);
    wr(4'd10, 8'h77);
    cnt_chk("w3", 3, 0);
    check("done_serve", 16'(done), 16'd0);
    wr(4'd3, 8'h99);
    cnt_chk("w_border", 4, 1);

    // finish with a concurrent write and read
    finish = 1;
    gray_req = 1; gray_addr = 4'd10;
    sb.push_back(8'h1A);
    wr(4'd6, 8'h42);
    finish = 0; gray_req = 0;
    check("done_rise", 16'(done), 16'd1);
    check("gray_ready_done", 16'(gray_ready), 16'd0);
    chk_sb("gray_finish", gray_data);
    cnt_chk("w_finish", 5, 1);

    // engine traffic ignored in DONE
    gray_req = 1; gray_addr = 4'd1;
    wr(4'd6, 8'h00);
    gray_req = 0;
    check("gray_ign", 16'(gray_data), 16'h1A);
    cnt_chk("w_ign", 5, 1);

    rd_back(4'd5, 8'h3C);
    rd_back(4'd10, 8'h77);
    rd_back(4'd6, 8'h42);
    rd_back(4'd3, 8'h99);
    cnt_chk("done_hold", 5, 1);

    // asynchronous reset out of DONE
    #2 reset = 0;
    #1;
    check("arst_done", 16'(done), 16'd0);
    check("arst_rd_data", 16'(rd_data), 16'd0);
    check("arst_gray_data", 16'(gray_data), 16'd0);
    check("arst_wr_cnt", 16'(wr_cnt), 16'd0);
    check("arst_border", 16'(border_err), 16'd0);
    tick();
    reset = 1;
    tick();

    // partial frame, then reset mid-load
    for (int i = 0; i < 7; i++) begin
      load_valid = 1; load_data = 8'h30 + 8'(i);
      tick();
    end
    load_valid = 0;
    #2 reset = 0;
    #1;
    check("mid_gray_ready", 16'(gray_ready), 16'd0);
    check("mid_wr_cnt", 16'(wr_cnt), 16'd0);
    tick();
    reset = 1;
    tick();

    load_frame(8'h20, 1'b0);
    read_pix(4'd0, 8'h20);
    read_pix(4'd7, 8'h27);
    read_pix(4'd15, 8'h2F);

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lbp_host.md
# lbp_host

Image-side responder for the LBP engine's pixel-fetch and result-write protocol.
- Holds the IMG_W×IMG_W grayscale frame, loaded through a byte-stream port.
- Raises `gray_ready` once the frame is complete, then answers `gray_req`/`gray_addr` reads with registered `gray_data`.
- Captures `lbp_valid`/`lbp_addr`/`lbp_data` writes into a result memory and makes it readable once the engine raises `finish`.
- Sits opposite the LBP controller in the top level and serves as the synthesizable host model for system simulation.

## Interface
Parameters:
- `IMG_W`, 128, image side in pixels; IMG_W×IMG_W must equal 2^ADDR_W
- `ADDR_W`, 14, pixel address width (row-major, addr = row*IMG_W + col)

Ports:
- `clk` input 1: single clock, all logic on rising edge
- `reset` input 1: asynchronous, active-low
- `load_valid` input 1: frame byte present on `load_data`
- `load_data` input 8: frame byte, row-major from address 0
- `gray_ready` output 1: frame loaded, engine may start
- `gray_req` input 1: pixel read request
- `gray_addr` input ADDR_W: pixel read address
- `gray_data` output 8: pixel data, valid the cycle after the request
- `lbp_valid` input 1: result write strobe
- `lbp_addr` input ADDR_W: result write address
- `lbp_data` input 8: result byte
- `finish` input 1: engine done
- `done` output 1: result memory frozen and readable
- `rd_addr` input ADDR_W: result readback address
- `rd_data` output 8: result readback data, one-cycle latency
- `wr_cnt` output ADDR_W+1: accepted result writes
- `border_err` output 1: sticky; a write hit a border pixel

## Operation
- State machine: LOAD → SERVE → DONE. Reset enters LOAD. DONE exits only on reset.
- LOAD:
  - Each cycle with `load_valid`=1: write `load_data` to gray_mem[load_ptr], then increment `load_ptr`.
  - The beat at `load_ptr`=2^ADDR_W−1 moves the FSM to SERVE.
  - `gray_req`, `lbp_valid` and `finish` are ignored.
- SERVE:
  - `gray_ready`=1.
  - `gray_req`=1: `gray_data` ← gray_mem[`gray_addr`] at the next edge. `gray_req`=0: `gray_data` holds.
  - `lbp_valid`=1: lbp_mem[`lbp_addr`] ← `lbp_data` and `wr_cnt` increments. Writes to the same address overwrite; each write still counts.
  - `load_valid` is ignored.
  - `finish`=1 moves the FSM to DONE. A `lbp_valid` in the same cycle is still committed and counted.
- DONE:
  - `done`=1 and `gray_ready`=0.
  - Reads and writes from the engine are ignored.
  - `rd_data` ← lbp_mem[`rd_addr`] every cycle.
- Border check: border means row 0, row IMG_W−1, col 0 or col IMG_W−1. Any accepted write with a border `lbp_addr` sets `border_err`; it clears only on reset.
- Widths:
  - `load_ptr` is ADDR_W bits and wraps to 0 on the transition beat.
  - `wr_cnt` saturates at 2^(ADDR_W+1)−1.
- Memory contents are not reset; their contents after reset are undefined.

## Timing
- Reset values: `gray_ready`=0, `gray_data`=0, `done`=0, `rd_data`=0, `wr_cnt`=0, `border_err`=0, `load_ptr`=0, state LOAD.
- `gray_ready` rises on the edge that accepts the final load beat. It is visible the cycle after that beat.
- Read latency is 1 cycle. A request in cycle N returns data in cycle N+1. Back-to-back requests give one datum per cycle.
- A request in the same cycle as `finish` is still served: `gray_data` updates once more.
- Result write, `wr_cnt` and `border_err` all update on the same edge as the strobe.
- `done` rises the cycle after `finish` is sampled.
- `rd_data` is valid one cycle after `rd_addr`, and only while `done`=1. Otherwise it holds 0.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - Loading restarts at address 0 after reset deasserts.

## Configuration
- `LBP_HOST_WRCHK_EN` defined: border check and `wr_cnt` counter are compiled in, as described above.
- `LBP_HOST_WRCHK_EN` undefined:
  - `border_err` is tied 0 and `wr_cnt` is tied 0.
  - Result writes and all other behaviour are unchanged.

## Test plan
Tests use IMG_W=4, ADDR_W=4.
- Load bytes 0x10..0x1F with gaps in `load_valid` → `gray_ready`=0 through the 16th beat and 1 the cycle after; extra `load_valid` beats leave memory unchanged.
- In SERVE, request addresses 5, 6, 9 back-to-back → `gray_data` = 0x15, 0x16, 0x19 on cycles N+1, N+2, N+3; it holds 0x19 after `gray_req` drops.
- Write 0xA5 to address 5, then 0x3C to address 5, then 0x77 to address 10 → readback after `finish`: addr 5 = 0x3C, addr 10 = 0x77; `wr_cnt`=3; `border_err`=0.
- Write to address 3 (row 0, col 3) → `border_err`=1 and sticky through DONE. Repeat with the macro undefined → `border_err`=0 and `wr_cnt`=0.
- `finish` together with `lbp_valid` (addr 6, 0x42) → `done`=1 next cycle and readback of addr 6 = 0x42. Later `lbp_valid` and `gray_req` are ignored.
- Assert `reset` low after 7 load beats → `gray_ready`=0 and `wr_cnt`=0 at once; a fresh 16-beat load starts at address 0 and raises `gray_ready`.
